// File: rtl/ctrl_sequencer.sv
// Micro-step sequencer for an 8-bit accumulator CPU: steps T0..T4 and decodes
// the instruction nibble into the 16-bit control word for the current step.
module ctrl_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step_en,
    input  logic [3:0]  i_opcode,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    output logic [15:0] o_ctrl,
    output logic [2:0]  o_step,
    output logic        o_halted
);

    typedef enum logic [2:0] {
        ST_T0 = 3'd0,
        ST_T1 = 3'd1,
        ST_T2 = 3'd2,
        ST_T3 = 3'd3,
        ST_T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [15:0] CW_FETCH0 = 16'h4004;
    localparam logic [15:0] CW_FETCH1 = 16'h1408;
    localparam logic [15:0] CW_MI_IO  = 16'h4800;
    localparam logic [15:0] CW_RO_AI  = 16'h1200;
    localparam logic [15:0] CW_RO_BI  = 16'h1020;
    localparam logic [15:0] CW_ADD    = 16'h0281;
    localparam logic [15:0] CW_SUB    = 16'h02C1;
    localparam logic [15:0] CW_AO_RI  = 16'h2100;
    localparam logic [15:0] CW_IO_AI  = 16'h0A00;
    localparam logic [15:0] CW_JUMP   = 16'h0802;
    localparam logic [15:0] CW_AO_OI  = 16'h0110;
    localparam logic [15:0] CW_HLT    = 16'h8000;
    localparam logic [15:0] CW_NONE   = 16'h0000;

    step_t step_r;
    step_t step_nxt_s;
    logic  halted_r;
    logic  halted_nxt_s;
    logic  [15:0] ctrl_s;

    // Number of micro-steps (fetch included) taken by an opcode.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        logic [2:0] len;
        case (op)
            OP_ADD, OP_SUB:                                 len = 3'd5;
            OP_LDA, OP_STA:                                 len = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   len = 3'd3;
            default:                                        len = 3'd2;
        endcase
        return len;
    endfunction

    // Step and halt state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_r   <= ST_T0;
            halted_r <= 1'b0;
        end else begin
            step_r   <= step_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    // Next-step decision; fetch steps always advance, opcode length matters from T1 on.
    always_comb begin
        step_nxt_s   = step_r;
        halted_nxt_s = halted_r;
        if (i_step_en && !halted_r) begin
            case (step_r)
                ST_T0: step_nxt_s = ST_T1;
                ST_T1: begin
                    if (instr_len(i_opcode) == 3'd2) begin
                        step_nxt_s = ST_T0;
                    end else begin
                        step_nxt_s = ST_T2;
                    end
                end
                ST_T2: begin
                    if (i_opcode == OP_HLT) begin
                        step_nxt_s   = ST_T0;
                        halted_nxt_s = 1'b1;
                    end else if (instr_len(i_opcode) == 3'd3) begin
                        step_nxt_s = ST_T0;
                    end else begin
                        step_nxt_s = ST_T3;
                    end
                end
                ST_T3: begin
                    if (instr_len(i_opcode) == 3'd4) begin
                        step_nxt_s = ST_T0;
                    end else begin
                        step_nxt_s = ST_T4;
                    end
                end
                ST_T4:   step_nxt_s = ST_T0;
                default: step_nxt_s = ST_T0;
            endcase
        end else begin
            step_nxt_s   = step_r;
            halted_nxt_s = halted_r;
        end
    end

    // Control word decode from step, opcode, flags and halt state.
    always_comb begin
        ctrl_s = CW_NONE;
        if (halted_r) begin
            ctrl_s = CW_HLT;
        end else begin
            case (step_r)
                ST_T0: ctrl_s = CW_FETCH0;
                ST_T1: ctrl_s = CW_FETCH1;
                ST_T2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_s = CW_MI_IO;
                        OP_LDI:  ctrl_s = CW_IO_AI;
                        OP_JMP:  ctrl_s = CW_JUMP;
                        OP_JC:   ctrl_s = i_flag_c ? CW_JUMP : CW_NONE;
                        OP_JZ:   ctrl_s = i_flag_z ? CW_JUMP : CW_NONE;
                        OP_OUT:  ctrl_s = CW_AO_OI;
                        OP_HLT:  ctrl_s = CW_HLT;
                        default: ctrl_s = CW_NONE;
                    endcase
                end
                ST_T3: begin
                    case (i_opcode)
                        OP_LDA:         ctrl_s = CW_RO_AI;
                        OP_ADD, OP_SUB: ctrl_s = CW_RO_BI;
                        OP_STA:         ctrl_s = CW_AO_RI;
                        default:        ctrl_s = CW_NONE;
                    endcase
                end
                ST_T4: begin
                    case (i_opcode)
                        OP_ADD:  ctrl_s = CW_ADD;
                        OP_SUB:  ctrl_s = CW_SUB;
                        default: ctrl_s = CW_NONE;
                    endcase
                end
                default: ctrl_s = CW_NONE;
            endcase
        end
    end

    assign o_ctrl   = ctrl_s;
    assign o_step   = step_r;
    assign o_halted = halted_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-feature tasks with hand-computed
// control words, plus a per-cycle single-bus-driver check.
module tb_ctrl_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_step_en = 1'b0;
    logic [3:0]  i_opcode = 4'h0;
    logic        i_flag_c = 1'b0;
    logic        i_flag_z = 1'b0;
    logic [15:0] o_ctrl;
    logic [2:0]  o_step;
    logic        o_halted;

    int total = 0;
    int bad   = 0;

    ctrl_sequencer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step_en(i_step_en),
        .i_opcode (i_opcode),
        .i_flag_c (i_flag_c),
        .i_flag_z (i_flag_z),
        .o_ctrl   (o_ctrl),
        .o_step   (o_step),
        .o_halted (o_halted)
    );

    always #5 i_clk = ~i_clk;

    // At most one of RO, IO, AO, EO, CO may drive the bus, checked every cycle.
    always @(negedge i_clk) begin
        logic [4:0] drv;
        drv = {o_ctrl[12], o_ctrl[11], o_ctrl[8], o_ctrl[7], o_ctrl[2]};
        total++;
        if ($countones(drv) > 1) begin
            bad++;
            $display("FAIL bus_driver: ctrl=%h has drivers %b, need at most one", o_ctrl, drv);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_step_en = 1'b1;
        apply_reset();
        total++;
        if (o_step !== 3'd0 || o_halted !== 1'b0 || o_ctrl !== 16'h4004) begin
            bad++;
            $display("FAIL reset: step=%0d halted=%b ctrl=%h, need 0 0 4004", o_step, o_halted, o_ctrl);
        end
    endtask

    task automatic test_lda();
        logic [15:0] ec [0:4];
        logic [2:0]  es [0:4];
        ec = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        apply_reset();
        i_opcode  = 4'h1;
        i_step_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (o_ctrl !== ec[i] || o_step !== es[i]) begin
                bad++;
                $display("FAIL lda[%0d]: ctrl=%h step=%0d, need %h %0d", i, o_ctrl, o_step, ec[i], es[i]);
            end
            tick();
        end
    endtask

    task automatic test_add_sub();
        logic [15:0] ec [0:5];
        for (int k = 0; k < 2; k++) begin
            ec = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h4004};
            if (k == 0) begin
                i_opcode = 4'h3;
                ec[4] = 16'h02C1;
            end else begin
                i_opcode = 4'h2;
            end
            apply_reset();
            i_step_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                total++;
                if (o_ctrl !== ec[i] || o_step !== ((i == 5) ? 3'd0 : 3'(i))) begin
                    bad++;
                    $display("FAIL alu op=%h T%0d: ctrl=%h step=%0d, need %h", i_opcode, i, o_ctrl, o_step, ec[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_cond_jump();
        logic [15:0] want;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            i_step_en = 1'b1;
            i_opcode  = (k < 2) ? 4'h7 : 4'h8;
            // the irrelevant flag is set opposite to catch a swapped flag
            if (k < 2) begin
                i_flag_c = k[0];
                i_flag_z = ~k[0];
            end else begin
                i_flag_z = k[0];
                i_flag_c = ~k[0];
            end
            want = k[0] ? 16'h0802 : 16'h0000;
            tick();
            tick();
            total++;
            if (o_step !== 3'd2 || o_ctrl !== want) begin
                bad++;
                $display("FAIL cjump op=%h flag=%0d: ctrl=%h step=%0d, need %h 2", i_opcode, k[0], o_ctrl, o_step, want);
            end
            // with stepping disabled the word follows the flag immediately
            i_step_en = 1'b0;
            if (k < 2) i_flag_c = ~i_flag_c;
            else       i_flag_z = ~i_flag_z;
            #1;
            total++;
            if (o_ctrl !== (16'h0802 ^ want) || o_step !== 3'd2) begin
                bad++;
                $display("FAIL cjump_track op=%h: ctrl=%h step=%0d, need %h 2", i_opcode, o_ctrl, o_step, 16'h0802 ^ want);
            end
            i_step_en = 1'b1;
            tick();
            total++;
            if (o_step !== 3'd0 || o_ctrl !== 16'h4004) begin
                bad++;
                $display("FAIL cjump_ret op=%h: step=%0d ctrl=%h, need 0 4004", i_opcode, o_step, o_ctrl);
            end
        end
        i_flag_c = 1'b0;
        i_flag_z = 1'b0;
    endtask

    task automatic test_decode_table();
        logic [3:0]  op   [0:8];
        logic [2:0]  len  [0:8];
        logic [15:0] t2   [0:8];
        logic [15:0] t3   [0:8];
        op  = '{4'h4, 4'h5, 4'h6, 4'hE, 4'h0, 4'hB, 4'h9, 4'hD, 4'h1};
        len = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4};
        t2  = '{16'h4800, 16'h0A00, 16'h0802, 16'h0110, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4800};
        t3  = '{16'h2100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1200};
        for (int e = 0; e < 9; e++) begin
            apply_reset();
            i_step_en = 1'b1;
            // opcode seen during T0 must not influence the fetch
            i_opcode = 4'hF;
            tick();
            i_opcode = op[e];
            total++;
            if (o_ctrl !== 16'h1408 || o_step !== 3'd1) begin
                bad++;
                $display("FAIL fetch op=%h: ctrl=%h step=%0d, need 1408 1", op[e], o_ctrl, o_step);
            end
            tick();
            if (len[e] == 3'd2) begin
                total++;
                if (o_step !== 3'd0 || o_ctrl !== 16'h4004) begin
                    bad++;
                    $display("FAIL short op=%h: step=%0d ctrl=%h, need 0 4004", op[e], o_step, o_ctrl);
                end
            end else begin
                total++;
                if (o_step !== 3'd2 || o_ctrl !== t2[e]) begin
                    bad++;
                    $display("FAIL t2 op=%h: step=%0d ctrl=%h, need 2 %h", op[e], o_step, o_ctrl, t2[e]);
                end
                tick();
                if (len[e] == 3'd4) begin
                    total++;
                    if (o_step !== 3'd3 || o_ctrl !== t3[e]) begin
                        bad++;
                        $display("FAIL t3 op=%h: step=%0d ctrl=%h, need 3 %h", op[e], o_step, o_ctrl, t3[e]);
                    end
                    tick();
                end
                total++;
                if (o_step !== 3'd0 || o_halted !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap op=%h: step=%0d halted=%b, need 0 0", op[e], o_step, o_halted);
                end
            end
        end
    endtask

    task automatic test_halt();
        apply_reset();
        i_step_en = 1'b1;
        i_opcode  = 4'hF;
        tick();
        tick();
        total++;
        if (o_step !== 3'd2 || o_ctrl !== 16'h8000 || o_halted !== 1'b0) begin
            bad++;
            $display("FAIL hlt_t2: step=%0d ctrl=%h halted=%b, need 2 8000 0", o_step, o_ctrl, o_halted);
        end
        tick();
        for (int i = 0; i < 11; i++) begin
            total++;
            if (o_halted !== 1'b1 || o_step !== 3'd0 || o_ctrl !== 16'h8000) begin
                bad++;
                $display("FAIL halted[%0d]: halted=%b step=%0d ctrl=%h, need 1 0 8000", i, o_halted, o_step, o_ctrl);
            end
            i_opcode  = 4'(i);
            i_step_en = (i % 3 != 2);
            tick();
        end
        i_step_en = 1'b1;
        apply_reset();
        total++;
        if (o_halted !== 1'b0 || o_step !== 3'd0 || o_ctrl !== 16'h4004) begin
            bad++;
            $display("FAIL hlt_reset: halted=%b step=%0d ctrl=%h, need 0 0 4004", o_halted, o_step, o_ctrl);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        i_opcode  = 4'h2;
        i_step_en = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            i_step_en = 1'b0;
            tick();
            total++;
            if (o_step !== 3'd3 || o_ctrl !== 16'h1020) begin
                bad++;
                $display("FAIL stall[%0d]: step=%0d ctrl=%h, need 3 1020", i, o_step, o_ctrl);
            end
        end
        i_step_en = 1'b1;
        tick();
        total++;
        if (o_step !== 3'd4 || o_ctrl !== 16'h0281) begin
            bad++;
            $display("FAIL resume: step=%0d ctrl=%h, need 4 0281", o_step, o_ctrl);
        end
        apply_reset();
        tick();
        tick();
        tick();
        i_step_en = 1'b0;
        apply_reset();
        total++;
        if (o_step !== 3'd0 || o_ctrl !== 16'h4004) begin
            bad++;
            $display("FAIL stall_reset: step=%0d ctrl=%h, need 0 4004", o_step, o_ctrl);
        end
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_lda();
        test_add_sub();
        test_cond_jump();
        test_decode_table();
        test_halt();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
